// File: rtl/round_robin_deficit_pkg.sv
// Shared constants and small vector helpers for the deficit round-robin scheduler.
package rr_pkg;

    localparam logic MODO_WRR      = 1'b0;
    localparam logic MODO_ESTRICTO = 1'b1;

    // Upper bounds for the generic helpers below; callers zero-extend into these widths.
    localparam int unsigned VEC_MAX = 256;
    localparam int unsigned ROT_MAX = 64;
    localparam int unsigned ROT_IW  = 6;

    // Field idx of width ancho from a packed vector of equal-width fields.
    function automatic logic [31:0] campo(input logic [VEC_MAX-1:0] vec,
                                          input int unsigned idx,
                                          input int unsigned ancho);
        campo = 32'(vec >> (idx * ancho)) & ((32'd1 << ancho) - 32'd1);
    endfunction

    // Rotate the low ancho bits of v right by n, so bit n lands at position 0.
    function automatic logic [ROT_MAX-1:0] rotar_der(input logic [ROT_MAX-1:0] v,
                                                     input int unsigned n,
                                                     input int unsigned ancho);
        rotar_der = '0;
        for (int unsigned k = 0; k < ROT_MAX; k++) begin
            if (k < ancho) begin
                rotar_der[ROT_IW'(k)] = v[ROT_IW'((k + n) % ancho)];
            end
        end
    endfunction

endpackage

// File: rtl/round_robin_deficit_buscador_circular.sv
// Circular first-set-bit search: lowest set bit of req at or after start, wrapping.
module buscador_circular
    import rr_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = 4,
    localparam int unsigned IW = $clog2(QUEUE_QUANTITY)
) (
    input  logic [QUEUE_QUANTITY-1:0] req,
    input  logic [IW-1:0]             start,
    output logic                      found,
    output logic [IW-1:0]             idx
);

    logic [QUEUE_QUANTITY-1:0] rot;
    logic [IW-1:0]             off;

    always_comb begin
        rot   = QUEUE_QUANTITY'(rotar_der(ROT_MAX'(req), 32'(start), QUEUE_QUANTITY));
        found = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < QUEUE_QUANTITY; k++) begin
            if (rot[IW'(k)] && !found) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        // QUEUE_QUANTITY is a power of two, so the IW-bit add wraps correctly.
        idx = start + off;
    end

endmodule

// File: rtl/round_robin_deficit.sv
// Weighted round-robin scheduler with per-turn credit, strict-priority mode and urgency.
module round_robin_deficit
    import rr_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned BUF_WIDTH      = 3,
    parameter int unsigned MAX_WEIGHT     = 64,
    parameter int unsigned UMBRAL_ALTO    = 6,
    localparam int unsigned WEIGHT_BITS   = $clog2(MAX_WEIGHT),
    localparam int unsigned SEL_BITS      = $clog2(QUEUE_QUANTITY)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic                                modo,
    input  logic                                dest_ready,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    output logic [SEL_BITS-1:0]                 selector,
    output logic                                selector_enb,
    output logic [WEIGHT_BITS-1:0]              creditos
);

    logic [SEL_BITS-1:0]       actual_q, actual_d;
    logic [WEIGHT_BITS-1:0]    creditos_q, creditos_d;
    logic                      modo_q, modo_d;

    logic [VEC_MAX-1:0]        pesos_ext, cnt_ext;
    logic [QUEUE_QUANTITY-1:0] elegible, urgente;
    logic [SEL_BITS-1:0]       start_rr, start_e;
    logic                      found_u, found_e;
    logic [SEL_BITS-1:0]       idx_u, idx_e;
    logic [SEL_BITS-1:0]       elegida;
    logic                      seguir;

    assign pesos_ext = VEC_MAX'(pesos);
    assign cnt_ext   = VEC_MAX'(fifo_counter);
    assign creditos  = creditos_q;

    always_comb begin
        elegible = '0;
        urgente  = '0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            elegible[SEL_BITS'(i)] = !buf_empty[SEL_BITS'(i)] &&
                                     (campo(pesos_ext, i, WEIGHT_BITS) != 32'd0);
            urgente[SEL_BITS'(i)]  = elegible[SEL_BITS'(i)] &&
                                     (campo(cnt_ext, i, BUF_WIDTH) >= 32'(UMBRAL_ALTO));
        end
    end

    // Search starts just past the current queue, so actual itself is checked last.
    assign start_rr = actual_q + SEL_BITS'(1);
    assign start_e  = (modo == MODO_ESTRICTO) ? '0 : start_rr;

    buscador_circular #(
        .QUEUE_QUANTITY(QUEUE_QUANTITY)
    ) u_busca_urgente (
        .req  (urgente),
        .start(start_rr),
        .found(found_u),
        .idx  (idx_u)
    );

    buscador_circular #(
        .QUEUE_QUANTITY(QUEUE_QUANTITY)
    ) u_busca_elegible (
        .req  (elegible),
        .start(start_e),
        .found(found_e),
        .idx  (idx_e)
    );

    // A turn survives only if the queue is still eligible, has credit, and we did not
    // just leave strict mode.
    assign seguir  = elegible[actual_q] && (creditos_q != '0) && (modo_q == MODO_WRR);
    assign elegida = found_u ? idx_u : idx_e;

    always_comb begin
        actual_d     = actual_q;
        creditos_d   = creditos_q;
        modo_d       = modo_q;
        selector     = actual_q;
        selector_enb = 1'b0;
        if (rst) begin
            selector = '0;
        end else if (enb && dest_ready) begin
            modo_d = modo;
            if (modo == MODO_ESTRICTO) begin
                creditos_d = '0;
                if (found_e) begin
                    selector     = idx_e;
                    selector_enb = 1'b1;
                    actual_d     = idx_e;
                end
            end else if (seguir) begin
                selector_enb = 1'b1;
                creditos_d   = creditos_q - WEIGHT_BITS'(1);
            end else if (found_e) begin
                // Any urgent queue is also eligible, so found_e covers both searches.
                selector     = elegida;
                selector_enb = 1'b1;
                actual_d     = elegida;
                creditos_d   = WEIGHT_BITS'(campo(pesos_ext, 32'(elegida), WEIGHT_BITS))
                               - WEIGHT_BITS'(1);
            end else begin
                creditos_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            actual_q   <= SEL_BITS'(QUEUE_QUANTITY - 1);
            creditos_q <= '0;
            modo_q     <= MODO_WRR;
        end else begin
            actual_q   <= actual_d;
            creditos_q <= creditos_d;
            modo_q     <= modo_d;
        end
    end

endmodule
